// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache.
// Load hits complete combinationally; misses refill a whole line, stores write through.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_wt #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_LINES  = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [3:0]              cpu_be,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    cpu_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [3:0]              mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
`endif
);

  localparam int unsigned WORD_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned OFF_W  = WORD_W + 2;
  localparam int unsigned TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int unsigned DEPTH  = NUM_LINES * LINE_WORDS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [WORD_W-1:0]     cnt;
  logic [NUM_LINES-1:0]  valid;
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [TAG_W-1:0]      tag_mem  [NUM_LINES];

  logic [TAG_W-1:0]      tag_in;
  logic [IDX_W-1:0]      idx;
  logic [WORD_W-1:0]     word;
  logic                  hit;
  logic                  load_hit;
  logic                  refill_start;
  logic                  refill_last;
  logic                  write_done;
  logic [DATA_WIDTH-1:0] cached_word;
  logic [DATA_WIDTH-1:0] merged_word;

  // Address decode and lookup straight from the CPU request
  assign tag_in       = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign idx          = cpu_addr[OFF_W +: IDX_W];
  assign word         = cpu_addr[2 +: WORD_W];
  assign hit          = valid[idx] && (tag_mem[idx] == tag_in);
  assign cached_word  = data_mem[{idx, word}];
  assign load_hit     = (state == IDLE) && cpu_req && !cpu_we && hit;
  assign refill_start = (state == IDLE) && cpu_req && !cpu_we && !hit;
  assign refill_last  = (state == REFILL) && mem_ack && (cnt == WORD_W'(LINE_WORDS - 1));
  assign write_done   = (state == WRITE) && mem_ack;

  // Byte-lane merge of store data into the cached word
  always_comb begin
    merged_word = cached_word;
    for (int b = 0; b < 4; b++) begin
      if (cpu_be[b]) merged_word[8*b +: 8] = cpu_wdata[8*b +: 8];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cpu_req && cpu_we) state_next = WRITE;
        else if (refill_start) state_next = REFILL;
      end
      REFILL:  if (refill_last) state_next = IDLE;
      WRITE:   if (mem_ack)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; memory side is driven purely from state and held CPU inputs
  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (load_hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = cached_word;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_be   = 4'b1111;
        mem_addr = {cpu_addr[ADDR_WIDTH-1:OFF_W], cnt, 2'b00};
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_be    = cpu_be;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_ready = mem_ack;
      end
      default: ;
    endcase
  end

  // Refill beat counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           cnt <= '0;
    else if (refill_start)              cnt <= '0;
    else if (state == REFILL && mem_ack) cnt <= cnt + 1'b1;
  end

  // Valid bits: cleared on refill entry so an aborted refill leaves the line invalid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              valid <= '0;
    else if (refill_start) valid[idx] <= 1'b0;
    else if (refill_last)  valid[idx] <= 1'b1;
  end

  // Data and tag arrays (not reset)
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ack) data_mem[{idx, cnt}] <= mem_rdata;
    else if (write_done && hit)     data_mem[{idx, word}] <= merged_word;
    if (refill_last) tag_mem[idx] <= tag_in;
  end

`ifdef DCACHE_STATS_EN
  logic after_refill;

  // The hit that completes a refilled load belongs to that miss, not to the hit count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) after_refill <= 1'b0;
    else      after_refill <= refill_last;
  end

  // Saturating hit/miss counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (load_hit && !after_refill && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if (refill_start && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Directed testbench for dcache_wt with a wait-state memory responder.
module tb_dcache_wt;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  beat_t       mem_log[$];
  logic [31:0] mem [1024];
  int          ack_delay;
  int          wait_cnt;
  int          errors;
  int          checks;

  dcache_wt dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_be    (cpu_be),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: acks after ack_delay wait cycles, logs every beat
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5000_0000 | 32'(i);
    mem[10'h040] = 32'hA0;
    mem[10'h041] = 32'hA1;
    mem[10'h042] = 32'hA2;
    mem[10'h043] = 32'hA3;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst && mem_req) begin
        if (wait_cnt < ack_delay) begin
          wait_cnt++;
        end else begin
          wait_cnt  = 0;
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr[11:2]];
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          end
          mem_log.push_back({mem_addr, mem_we, mem_be, mem_wdata});
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // One CPU access; returns data, cycles to ready (1 = same cycle) and mem_req at ready
  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output int cyc, output logic mreq);
    logic done;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wdata;
    done = 1'b0; cyc = 0; rdata = '0; mreq = 1'b0;
    while (!done && cyc < 300) begin
      #4;
      cyc++;
      if (cpu_ready) begin
        done  = 1'b1;
        rdata = cpu_rdata;
        mreq  = mem_req;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL op_timeout addr=%h: cpu_ready never rose", addr);
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h100;
    #2;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_cpu_ready got %b want 0", cpu_ready); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata got %h want 0", cpu_rdata); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_be !== 4'h0) begin errors++; $display("FAIL rst_mem_be got %h want 0", mem_be); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mem_log.delete();
  endtask

  task automatic test_refill();
    logic [31:0] rd; int cyc; logic mr;
    ack_delay = 2;
    mem_log.delete();
    cpu_op(1'b0, 32'h100, 4'h0, 32'h0, rd, cyc, mr);
    checks++; if (rd !== 32'hA0) begin errors++; $display("FAIL refill_data got %h want A0", rd); end
    checks++; if (cyc !== 14) begin errors++; $display("FAIL refill_latency got %0d want 14", cyc); end
    checks++; if (mem_log.size() !== 4) begin errors++; $display("FAIL refill_beats got %0d want 4", mem_log.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < mem_log.size()) begin
        checks++;
        if (mem_log[i].addr !== 32'h100 + 32'(4 * i) || mem_log[i].we !== 1'b0 || mem_log[i].be !== 4'hF) begin
          errors++;
          $display("FAIL refill_beat%0d got addr=%h we=%b be=%h want addr=%h we=0 be=f",
                   i, mem_log[i].addr, mem_log[i].we, mem_log[i].be, 32'h100 + 32'(4 * i));
        end
      end
    end
    mem_log.delete();
    cpu_op(1'b0, 32'h108, 4'h0, 32'h0, rd, cyc, mr);
    checks++; if (rd !== 32'hA2) begin errors++; $display("FAIL hit_data got %h want A2", rd); end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL hit_latency got %0d want 1", cyc); end
    checks++; if (mr !== 1'b0) begin errors++; $display("FAIL hit_mem_req got %b want 0", mr); end
    checks++; if (mem_log.size() !== 0) begin errors++; $display("FAIL hit_no_mem got %0d beats want 0", mem_log.size()); end
  endtask

  task automatic test_store_hit();
    logic [31:0] rd; int cyc; logic mr;
    ack_delay = 1;
    cpu_op(1'b1, 32'h104, 4'hF, 32'h1122_3344, rd, cyc, mr);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL store_latency got %0d want 3", cyc); end
    checks++; if (mr !== 1'b1) begin errors++; $display("FAIL store_mem_req got %b want 1", mr); end
    mem_log.delete();
    cpu_op(1'b1, 32'h104, 4'b0011, 32'hAAAA_5555, rd, cyc, mr);
    checks++; if (mem_log.size() !== 1) begin errors++; $display("FAIL store_beats got %0d want 1", mem_log.size()); end
    if (mem_log.size() > 0) begin
      checks++;
      if (mem_log[0].addr !== 32'h104 || mem_log[0].we !== 1'b1 || mem_log[0].be !== 4'b0011 || mem_log[0].wdata !== 32'hAAAA_5555) begin
        errors++;
        $display("FAIL store_beat got addr=%h we=%b be=%b wdata=%h want 104 1 0011 aaaa5555",
                 mem_log[0].addr, mem_log[0].we, mem_log[0].be, mem_log[0].wdata);
      end
    end
    cpu_op(1'b0, 32'h104, 4'h0, 32'h0, rd, cyc, mr);
    checks++; if (rd !== 32'h1122_5555) begin errors++; $display("FAIL store_merge got %h want 11225555", rd); end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL store_merge_hit got %0d want 1", cyc); end
    mem_log.delete();
    cpu_op(1'b1, 32'h108, 4'h0, 32'hFFFF_FFFF, rd, cyc, mr);
    checks++; if (mem_log.size() !== 1) begin errors++; $display("FAIL be0_beats got %0d want 1", mem_log.size()); end
    cpu_op(1'b0, 32'h108, 4'h0, 32'h0, rd, cyc, mr);
    checks++; if (rd !== 32'hA2) begin errors++; $display("FAIL be0_data got %h want A2", rd); end
  endtask

  task automatic test_store_miss();
    logic [31:0] rd; int cyc; logic mr;
    ack_delay = 0;
    mem_log.delete();
    cpu_op(1'b1, 32'h200, 4'hF, 32'hCAFE_F00D, rd, cyc, mr);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL smiss_latency got %0d want 2", cyc); end
    checks++; if (mem_log.size() !== 1) begin errors++; $display("FAIL smiss_beats got %0d want 1", mem_log.size()); end
    mem_log.delete();
    cpu_op(1'b0, 32'h200, 4'h0, 32'h0, rd, cyc, mr);
    checks++; if (mem_log.size() !== 4) begin errors++; $display("FAIL smiss_noalloc got %0d beats want 4", mem_log.size()); end
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL smiss_data got %h want cafef00d", rd); end
    checks++; if (cyc !== 6) begin errors++; $display("FAIL smiss_refill_latency got %0d want 6", cyc); end
  endtask

  task automatic test_conflict();
    logic [31:0] rd; int cyc; logic mr;
    ack_delay = 0;
    cpu_op(1'b0, 32'h100, 4'h0, 32'h0, rd, cyc, mr);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL conf_prehit got %0d want 1", cyc); end
    mem_log.delete();
    cpu_op(1'b0, 32'h500, 4'h0, 32'h0, rd, cyc, mr);
    checks++; if (mem_log.size() !== 4) begin errors++; $display("FAIL conf_refill got %0d beats want 4", mem_log.size()); end
    checks++; if (rd !== 32'h5000_0140) begin errors++; $display("FAIL conf_data got %h want 50000140", rd); end
    mem_log.delete();
    cpu_op(1'b0, 32'h100, 4'h0, 32'h0, rd, cyc, mr);
    checks++; if (mem_log.size() !== 4) begin errors++; $display("FAIL conf_evict got %0d beats want 4", mem_log.size()); end
    checks++; if (rd !== 32'hA0) begin errors++; $display("FAIL conf_reload got %h want A0", rd); end
    cpu_op(1'b0, 32'h104, 4'h0, 32'h0, rd, cyc, mr);
    checks++; if (rd !== 32'h1122_5555) begin errors++; $display("FAIL conf_wt_data got %h want 11225555", rd); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    #4;
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hA0) begin
      errors++; $display("FAIL b2b_first got ready=%b data=%h want 1 A0", cpu_ready, cpu_rdata);
    end
    @(posedge clk);
    #1;
    cpu_addr = 32'h108;
    #3;
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hA2 || mem_req !== 1'b0) begin
      errors++; $display("FAIL b2b_second got ready=%b data=%h req=%b want 1 A2 0", cpu_ready, cpu_rdata, mem_req);
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; int cyc; logic mr;
    ack_delay = 0;
    cpu_op(1'b0, 32'h500, 4'h0, 32'h0, rd, cyc, mr);
    ack_delay = 1;
    mem_log.delete();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    for (int i = 0; i < 100 && mem_log.size() < 2; i++) @(negedge clk);
    checks++; if (mem_log.size() !== 2) begin errors++; $display("FAIL abort_two_acks got %0d want 2", mem_log.size()); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL abort_mem_req got %b want 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL abort_mem_addr got %h want 0", mem_addr); end
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ack_delay = 0;
    mem_log.delete();
    cpu_op(1'b0, 32'h100, 4'h0, 32'h0, rd, cyc, mr);
    checks++; if (mem_log.size() !== 4) begin errors++; $display("FAIL abort_refill got %0d beats want 4", mem_log.size()); end
    if (mem_log.size() == 4) begin
      checks++;
      if (mem_log[0].addr !== 32'h100 || mem_log[3].addr !== 32'h10C) begin
        errors++; $display("FAIL abort_addrs got %h..%h want 100..10c", mem_log[0].addr, mem_log[3].addr);
      end
    end
    checks++; if (rd !== 32'hA0) begin errors++; $display("FAIL abort_data got %h want A0", rd); end
    checks++; if (cyc !== 6) begin errors++; $display("FAIL abort_latency got %0d want 6", cyc); end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    logic [31:0] rd; int cyc; logic mr;
    ack_delay = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      errors++; $display("FAIL stats_reset got hit=%0d miss=%0d want 0 0", hit_count, miss_count);
    end
    @(negedge clk);
    rst = 1'b1;
    cpu_op(1'b0, 32'h100, 4'h0, 32'h0, rd, cyc, mr);
    for (int i = 0; i < 3; i++) cpu_op(1'b0, 32'h104 + 32'(4 * i), 4'h0, 32'h0, rd, cyc, mr);
    cpu_op(1'b1, 32'h104, 4'h0, 32'h0, rd, cyc, mr);
    checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL stats_miss got %0d want 1", miss_count); end
    checks++; if (hit_count !== 32'd3) begin errors++; $display("FAIL stats_hit got %0d want 3", hit_count); end
  endtask
`endif

  initial begin
    errors = 0; checks = 0; ack_delay = 0;
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0;
    cpu_addr = '0; cpu_wdata = '0;
    test_reset();
    test_refill();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_back_to_back();
    test_reset_abort();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits directly downstream of the execute stage's load/store path and in front of main data memory.
- Read hits complete in the same cycle, preserving single-cycle timing for the CPU.
- Misses and all stores stall the CPU through `cpu_ready` while a valid/ack memory transaction runs.

Parameters:
- DATA_WIDTH, 32, word width; fixed at 32 (4 byte lanes).
- ADDR_WIDTH, 32, byte address width.
- NUM_LINES, 64, number of lines; power of two, at least 2.
- LINE_WORDS, 4, words per line; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  load/store request valid.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_be  in  4  store byte enables; ignored for loads.
- cpu_addr  in  ADDR_WIDTH  byte address, word aligned.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_rdata  out  DATA_WIDTH  load data; valid when `cpu_ready` is high.
- cpu_ready  out  1  request completes this cycle.
- mem_req  out  1  memory transaction valid.
- mem_we  out  1  memory write.
- mem_be  out  4  memory byte enables.
- mem_addr  out  ADDR_WIDTH  memory word address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ack  in  1  memory completes the current beat this cycle.
- mem_rdata  in  DATA_WIDTH  read data; valid with `mem_ack`.

Behaviour:
- Address split: byte = [1:0]; word = next log2(LINE_WORDS) bits; index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- Storage: data array, tag array, and one valid bit per line. Only the valid bits are reset.
- Reset (`rst` low):
  - all valid bits cleared; state = IDLE; refill counter = 0.
  - `mem_req`, `mem_we`, `cpu_ready` = 0.
  - `cpu_rdata`, `mem_addr`, `mem_wdata`, `mem_be` = 0.
  - Any refill or write in progress is aborted; the affected line stays invalid.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - Load hit (valid && tag match): `cpu_ready` = 1 combinationally in the same cycle; `cpu_rdata` = cached word. No state change.
  - Load miss: `cpu_ready` = 0; next state REFILL; counter = 0; the line's valid bit is cleared on entry.
  - Store: `cpu_ready` = 0; next state WRITE.
  - No request: `cpu_ready` = 0; `cpu_rdata` = 0.
- REFILL:
  - `mem_req` = 1, `mem_we` = 0, `mem_be` = 4'b1111.
  - `mem_addr` = line base + counter*4.
  - Each `mem_ack` writes `mem_rdata` into the line word[counter], then counter increments.
  - On ack of the last word: write tag, set valid, return to IDLE.
  - The CPU's held request then hits in the following cycle (miss penalty = LINE_WORDS acks + 1 cycle).
- WRITE:
  - `mem_req` = 1, `mem_we` = 1; `mem_addr` = `cpu_addr`; `mem_wdata` = `cpu_wdata`; `mem_be` = `cpu_be`.
  - On `mem_ack`:
    - If the line hits, merge the enabled bytes into the cached word.
    - `cpu_ready` = 1 in the same cycle; return to IDLE.
  - A store miss does not allocate.
- Handshake rules:
  - `mem_req` and all `mem_*` outputs are stable until `mem_ack`.
  - `mem_ack` is ignored while `mem_req` = 0.
  - Memory may insert any number of wait states.
  - The CPU holds `cpu_req` and its inputs stable until `cpu_ready`.
  - A store with `cpu_be` = 0 still performs the memory transaction.
- Indexing: tag/index compare uses `cpu_addr` directly, so a new request is accepted in the cycle after completion (no bubble).
- Counter wrap: the counter width is log2(LINE_WORDS). It wraps to 0 only after the last ack, which is also the REFILL exit.

Optional Feature:
- Macro: `DCACHE_STATS_EN`
- Defined:
  - Adds outputs `hit_count` (32 bits) and `miss_count` (32 bits); both reset to 0 and saturate at 0xFFFFFFFF.
  - `hit_count` increments on each completed load hit.
  - `miss_count` increments on each REFILL entry.
  - Stores do not count.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then load 0x100 with memory words 0xA0..0xA3 and 2-cycle ack delay -> `mem_addr` sequence 0x100, 0x104, 0x108, 0x10C. `cpu_ready` rises the cycle after the 4th ack with `cpu_rdata` = 0xA0. A subsequent load of 0x108 gets `cpu_ready` in the same cycle with 0xA2 and `mem_req` = 0.
- Line holding 0x104 = 0x11223344; store 0x104, `cpu_be` = 4'b0011, data 0xAAAA5555 -> `mem_we` = 1, `mem_be` = 0011, ready on ack. The next load of 0x104 hits with 0x11225555.
- Store miss to 0x200 -> one memory write, then IDLE. A load of 0x200 then misses and refills (no allocate).
- Conflict (default params): load 0x100, then load 0x500 (same index 0x10) -> second load refills. Loading 0x100 again misses.
- Assert `rst` after 2 refill acks -> `mem_req` drops immediately. After release, a load of 0x100 performs a full 4-beat refill.
- With `DCACHE_STATS_EN`: 1 miss followed by 3 hits on the same line -> `miss_count` = 1, `hit_count` = 3.
